// File: rtl/complement_seq.sv
// Serial two's-complement negator: one nibble per clock through a 4-bit invert+carry datapath.
// Optional COMPLEMENT_SAT_EN: saturate the most-negative operand to max positive instead of wrapping.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; Q/ovf hold last result
// S_RUN  | one nibble negated per clock, LSB first, NIBBLES clocks total
module complement_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] D,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Q,
  output logic                 ovf
);

  localparam int W = 4 * NIBBLES;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [3:0]   CNT_LAST = 4'(NIBBLES - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef COMPLEMENT_SAT_EN
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
`endif

  logic         state_q,    state_d;
  logic [W-1:0] sr_q,       sr_d;
  logic [W-1:0] res_q,      res_d;
  logic         carry_q,    carry_d;
  logic [3:0]   cnt_q,      cnt_d;
  logic         ovf_pend_q, ovf_pend_d;
  logic [W-1:0] q_q,        q_d;
  logic         ovf_q,      ovf_d;
  logic         done_q,     done_d;

  logic [3:0]   nib;
  logic [3:0]   r_nib;
  logic [W-1:0] assembled;

  assign nib       = sr_q[3:0];
  assign r_nib     = ~nib + {3'b000, carry_q};
  assign assembled = {r_nib, res_q[W-1:4]};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    res_d      = res_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    q_d        = q_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          sr_d       = D;
          res_d      = '0;
          carry_d    = 1'b1;
          cnt_d      = 4'h0;
          ovf_pend_d = (D == MOST_NEG);
        end
      end
      S_RUN: begin
        // carry only ripples past a nibble that inverts to all ones
        sr_d    = {4'h0, sr_q[W-1:4]};
        res_d   = assembled;
        carry_d = carry_q & (nib == 4'h0);
        cnt_d   = cnt_q + 4'h1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
`ifdef COMPLEMENT_SAT_EN
          q_d     = ovf_pend_q ? MAX_POS : assembled;
`else
          q_d     = assembled;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= 4'h0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign Q    = q_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_complement_seq.sv
// Directed bench for complement_seq with NIBBLES=4; expected values are hand-computed negations.
// Build with COMPLEMENT_SAT_EN to check the saturating variant of the most-negative case.
module tb_complement_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] D;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  complement_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one accept edge, then count cycles until done (bounded).
  task automatic launch(input logic [15:0] op, output int lat);
    @(negedge clk);
    start = 1'b1;
    D     = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    D     = 16'hDEAD;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    D     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, ovf} !== 3'b000 || Q !== 16'h0000) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b ovf=%b Q=%h, want 0 0 0 0000", busy, done, ovf, Q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_negate(input logic [15:0] op, input logic [15:0] exp_q,
                             input logic exp_ovf, input string name);
    int lat;
    launch(op, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    total++;
    if (Q !== exp_q || ovf !== exp_ovf || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s result: Q=%h ovf=%b busy=%b want Q=%h ovf=%b busy=0",
               name, Q, ovf, busy, exp_q, exp_ovf);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || Q !== exp_q || ovf !== exp_ovf) begin
      bad++;
      $display("FAIL %s hold: done=%b Q=%h ovf=%b want done=0 Q=%h ovf=%b",
               name, done, Q, ovf, exp_q, exp_ovf);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int first = -1;
    logic [15:0] prev_q;
    prev_q = Q;
    @(negedge clk);
    start = 1'b1;
    D     = 16'h00F0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) begin
        start = 1'b1;
        D     = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 2) begin
        total++;
        if (Q !== prev_q || busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_hold: Q=%h busy=%b want Q=%h busy=1", Q, busy, prev_q);
        end
      end
      if (done) begin
        dones++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (dones !== 1 || first !== 4) begin
      bad++;
      $display("FAIL busy_drop: dones=%0d first=%0d want 1 at 4", dones, first);
    end
    total++;
    if (Q !== 16'hFF10 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL busy_result: Q=%h ovf=%b want ff10 0", Q, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [15:0] q1 = 16'h0000;
    logic [15:0] q2 = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    D     = 16'h0002;
    @(posedge clk);
    #1;
    D = 16'h0003;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done && d1 < 0) begin
        d1 = i;
        q1 = Q;
      end else if (done && d2 < 0) begin
        d2 = i;
        q2 = Q;
      end
    end
    start = 1'b0;
    total++;
    if (d1 !== 4 || d2 !== 9) begin
      bad++;
      $display("FAIL b2b_timing: done at %0d,%0d want 4,9", d1, d2);
    end
    total++;
    if (q1 !== 16'hFFFE || q2 !== 16'hFFFD) begin
      bad++;
      $display("FAIL b2b_result: Q=%h,%h want fffe,fffd", q1, q2);
    end
    for (int i = 0; i < 20 && busy; i++) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    @(negedge clk);
    start = 1'b1;
    D     = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, ovf} !== 3'b000 || Q !== 16'h0000) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b ovf=%b Q=%h want 0 0 0 0000", busy, done, ovf, Q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0 || Q !== 16'h0000) begin
      bad++;
      $display("FAIL abort_quiet: activity=%0d Q=%h want 0 0000", dones, Q);
    end
  endtask

  initial begin
    test_reset();
    test_negate(16'h0001, 16'hFFFF, 1'b0, "neg_0001");
    test_negate(16'h1234, 16'hEDCC, 1'b0, "neg_1234");
    test_negate(16'h0000, 16'h0000, 1'b0, "neg_0000");
`ifdef COMPLEMENT_SAT_EN
    test_negate(16'h8000, 16'h7FFF, 1'b1, "neg_8000");
`else
    test_negate(16'h8000, 16'h8000, 1'b1, "neg_8000");
`endif
    test_negate(16'h7FFF, 16'h8001, 1'b0, "neg_7fff");
    test_negate(16'hFFFF, 16'h0001, 1'b0, "neg_ffff");
    test_start_while_busy();
    test_back_to_back();
    test_negate(16'hA5C3, 16'h5A3D, 1'b0, "neg_a5c3");
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
